// File: rtl/sa_pkg.sv
// Package for the systolic-array tile sequencer.
// Holds the element types shared between the sequencer, the skew line and
// the SA_CORE boundary, the sequencer state encoding, and a saturating
// increment helper that the optional performance counters use.
//
// Optional feature macro: SA_SEQ_PERF_EN (used by sa_tile_sequencer).

package sa_pkg;

    typedef logic [7:0]  act_t;   // activation element
    typedef logic [7:0]  wgt_t;   // weight element
    typedef logic [31:0] acc_t;   // accumulator / result element

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STREAM = 2'd1,
        SEQ_FLUSH  = 2'd2,
        SEQ_DRAIN  = 2'd3
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Diagonal skew for one systolic-array edge pair (activation + weight).
// Lane r of each input vector is delayed by r clock cycles; lane 0 passes
// straight through. All shift stages clear on reset, so lanes that have not
// yet received data present zero.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   a_in / w_in     ROWS x W input vectors (already zero when not valid)
//   a_out / w_out   ROWS x W skewed vectors toward the array edge

module sa_skew_line #(
    parameter int ROWS = 8,
    parameter int W    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ROWS-1:0][W-1:0] a_in,
    input  logic [ROWS-1:0][W-1:0] w_in,
    output logic [ROWS-1:0][W-1:0] a_out,
    output logic [ROWS-1:0][W-1:0] w_out
);

    assign a_out[0] = a_in[0];
    assign w_out[0] = w_in[0];

    for (genvar r = 1; r < ROWS; r++) begin : g_lane
        // Stage 0 takes the new sample; stage r-1 feeds the output.
        logic [r-1:0][W-1:0] a_sh_q;
        logic [r-1:0][W-1:0] a_sh_d;
        logic [r-1:0][W-1:0] w_sh_q;
        logic [r-1:0][W-1:0] w_sh_d;

        always_comb begin
            a_sh_d[0] = a_in[r];
            w_sh_d[0] = w_in[r];
            for (int k = 1; k < r; k++) begin
                a_sh_d[k] = a_sh_q[k-1];
                w_sh_d[k] = w_sh_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                a_sh_q <= '0;
                w_sh_q <= '0;
            end else begin
                a_sh_q <= a_sh_d;
                w_sh_q <= w_sh_d;
            end
        end

        assign a_out[r] = a_sh_q[r-1];
        assign w_out[r] = w_sh_q[r-1];
    end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Sequences one output-stationary tile through SA_CORE.
//
// Flow: IDLE -> STREAM -> FLUSH -> DRAIN -> IDLE.
//   IDLE    accepts a tile command (cmd_ready high only here). A zero-length
//           command just pulses done on the next cycle.
//   STREAM  issues cmd_len consecutive buffer reads at base, base+1, ...
//           (address wraps at 2^ADDR_W). Read data returns one cycle later
//           and enters the skew line.
//   FLUSH   skew input is zero; lasts 2*ROWS cycles counted from the last
//           returned data cycle (ROWS-1 to empty the skew, ROWS to propagate).
//           inpvalid is high from the first returned data cycle to the end
//           of FLUSH: cmd_len + 2*ROWS - 1 contiguous cycles.
//   DRAIN   once rvalidport is all-ones and no result is pending, pulses
//           outread for one cycle and captures routport at the end of that
//           cycle; res_valid then holds res_data until res_ready, after
//           which done pulses and the block returns to IDLE.
//
// Handshakes: cmd and res are valid/ready; a transfer happens on a rising
// clock edge where both valid and ready are high. valid, once raised, holds
// its payload stable until that transfer.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   cmd_valid/ready/base/len     tile command
//   mem_ren/raddr/rdata_a/rdata_w  1-cycle-latency buffer read port
//   ainport/winport/inpvalid/outread/routport/rvalidport  SA_CORE side
//   res_valid/ready/data         result vector to consumer
//   busy, done                   status (done is a one-cycle pulse)
//   perf_busy_cyc, perf_stall_cyc  only with SA_SEQ_PERF_EN defined
//   dbg_state                    current sequencer state
//
// Optional feature macro: SA_SEQ_PERF_EN adds saturating busy-cycle and
// drain-stall-cycle counters, cleared only by reset.

module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_base,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   mem_ren,
    output logic [ADDR_W-1:0]      mem_raddr,
    input  act_t [ROWS-1:0]        mem_rdata_a,
    input  wgt_t [ROWS-1:0]        mem_rdata_w,
    output act_t [ROWS-1:0]        ainport,
    output wgt_t [ROWS-1:0]        winport,
    output logic                   inpvalid,
    output logic                   outread,
    input  acc_t [ROWS-1:0]        routport,
    input  logic [ROWS-1:0]        rvalidport,
    output logic                   res_valid,
    input  logic                   res_ready,
    output acc_t [ROWS-1:0]        res_data,
    output logic                   busy,
    output logic                   done,
`ifdef SA_SEQ_PERF_EN
    output logic [31:0]            perf_busy_cyc,
    output logic [31:0]            perf_stall_cyc,
`endif
    output seq_state_e             dbg_state
);

    localparam int FL_W = $clog2(2 * ROWS);
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2 * ROWS - 1);

    seq_state_e          state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [LEN_W-1:0]    len_q,       len_d;
    logic [LEN_W-1:0]    cnt_q,       cnt_d;
    logic                ren_q,       ren_d;
    logic                rd_valid_q,  rd_valid_d;
    logic                inpvalid_q,  inpvalid_d;
    logic [FL_W-1:0]     flush_q,     flush_d;
    logic                outread_q,   outread_d;
    logic                res_valid_q, res_valid_d;
    acc_t [ROWS-1:0]     res_data_q,  res_data_d;
    logic                done_q,      done_d;

    act_t [ROWS-1:0]     skew_a_in;
    wgt_t [ROWS-1:0]     skew_w_in;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ren_d       = ren_q;
        rd_valid_d  = ren_q;      // buffer answers one cycle after a read
        inpvalid_d  = inpvalid_q;
        flush_d     = flush_q;
        outread_d   = outread_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            SEQ_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEQ_STREAM;
                        ren_d   = 1'b1;
                        addr_d  = cmd_base;
                        len_d   = cmd_len;
                        cnt_d   = '0;
                    end
                end
            end
            SEQ_STREAM: begin
                // Data for the read issued this cycle arrives next cycle,
                // which is where inpvalid must start.
                inpvalid_d = 1'b1;
                if (cnt_q == len_q - LEN_W'(1)) begin
                    ren_d   = 1'b0;
                    flush_d = '0;
                    state_d = SEQ_FLUSH;
                end else begin
                    cnt_d  = cnt_q + LEN_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            SEQ_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    inpvalid_d = 1'b0;
                    state_d    = SEQ_DRAIN;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            SEQ_DRAIN: begin
                if (outread_q) begin
                    outread_d   = 1'b0;
                    res_data_d  = routport;
                    res_valid_d = 1'b1;
                end else if (res_valid_q) begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = SEQ_IDLE;
                    end
                end else if (&rvalidport) begin
                    outread_d = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SEQ_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            ren_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            inpvalid_q  <= 1'b0;
            flush_q     <= '0;
            outread_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ren_q       <= ren_d;
            rd_valid_q  <= rd_valid_d;
            inpvalid_q  <= inpvalid_d;
            flush_q     <= flush_d;
            outread_q   <= outread_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    // Read data is only meaningful the cycle after a read; everywhere else
    // (including all of FLUSH after the last return) the skew sees zeros.
    assign skew_a_in = rd_valid_q ? mem_rdata_a : '0;
    assign skew_w_in = rd_valid_q ? mem_rdata_w : '0;

    sa_skew_line #(
        .ROWS (ROWS),
        .W    (8)
    ) u_skew (
        .clk   (clk),
        .rstn  (rstn),
        .a_in  (skew_a_in),
        .w_in  (skew_w_in),
        .a_out (ainport),
        .w_out (winport)
    );

`ifdef SA_SEQ_PERF_EN
    logic [31:0] perf_busy_q,  perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (state_q != SEQ_IDLE) begin
            perf_busy_d = sat_inc32(perf_busy_q);
        end
        // Core has a full result but the previous one is still unconsumed.
        if (state_q == SEQ_DRAIN && (&rvalidport) && res_valid_q) begin
            perf_stall_d = sat_inc32(perf_stall_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
`endif

    assign cmd_ready = (state_q == SEQ_IDLE);
    assign busy      = (state_q != SEQ_IDLE);
    assign mem_ren   = ren_q;
    assign mem_raddr = addr_q;
    assign inpvalid  = inpvalid_q;
    assign outread   = outread_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
module tb_sa_tile_sequencer;
  import sa_pkg::*;

  localparam int ROWS   = 8;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                    cmd_valid, cmd_ready;
  logic [ADDR_W-1:0]       cmd_base;
  logic [LEN_W-1:0]        cmd_len;
  logic                    mem_ren;
  logic [ADDR_W-1:0]       mem_raddr;
  logic [ROWS-1:0][7:0]    mem_rdata_a, mem_rdata_w;
  logic [ROWS-1:0][7:0]    ainport, winport;
  logic                    inpvalid, outread;
  logic [ROWS-1:0][31:0]   routport;
  logic [ROWS-1:0]         rvalidport;
  logic                    res_valid, res_ready;
  logic [ROWS-1:0][31:0]   res_data;
  logic                    busy, done;
  seq_state_e              dbg_state;

  sa_tile_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata_a(mem_rdata_a), .mem_rdata_w(mem_rdata_w),
    .ainport(ainport), .winport(winport), .inpvalid(inpvalid), .outread(outread),
    .routport(routport), .rvalidport(rvalidport),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- buffer model (1-cycle read latency) ----------------
  int unsigned seed_a, seed_w;
  int dmode = 0;   // 1: activation lane r = r+1

  function automatic logic [7:0] elem(input logic [ADDR_W-1:0] addr, input int r,
                                      input int unsigned seed);
    logic [31:0] h;
    h = (32'(addr) * 32'h9E3779B1) ^ (seed + 32'(r) * 32'h85EBCA6B);
    h = h ^ (h >> 13);
    return h[7:0] | 8'h01;   // never zero so misplaced lanes show up
  endfunction

  function automatic logic [7:0] data_a(input logic [ADDR_W-1:0] addr, input int r);
    if (dmode == 1) return 8'(r + 1);
    return elem(addr, r, seed_a);
  endfunction

  function automatic logic [7:0] data_w(input logic [ADDR_W-1:0] addr, input int r);
    return elem(addr, r, seed_w);
  endfunction

  logic                  ren_d1 = 1'b0;
  logic [ADDR_W-1:0]     raddr_d1 = '0;
  logic [ROWS-1:0][7:0]  junk_a = '0, junk_w = '0;

  always @(posedge clk) begin
    ren_d1   <= mem_ren;
    raddr_d1 <= mem_raddr;
    junk_a   <= {$urandom, $urandom};
    junk_w   <= {$urandom, $urandom};
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      mem_rdata_a[r] = ren_d1 ? data_a(raddr_d1, r) : junk_a[r];
      mem_rdata_w[r] = ren_d1 ? data_w(raddr_d1, r) : junk_w[r];
    end
  end

  // ---------------- core model ----------------
  logic rv_all = 1'b0;
  always @(posedge clk) begin
    logic [ROWS-1:0] p;
    logic [ROWS-1:0][31:0] rt;
    p = ROWS'($urandom);
    p[$urandom_range(0, ROWS - 1)] = 1'b0;   // partial: never all-ones
    for (int r = 0; r < ROWS; r++) rt[r] = $urandom;
    rvalidport <= rv_all ? '1 : p;
    routport   <= rt;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [ADDR_W-1:0] exp_q[$];     // expected read addresses, in order
  logic [ADDR_W-1:0] cur_base;
  int cur_len;
  int ren_cnt, ren_first, ren_last;
  int iv_cnt, iv_first, iv_last;
  int or_cnt, or_cyc, all1_first;
  int rv_cnt, rv_first, hs_cyc;
  int done_cnt, done_cyc;
  logic [ROWS-1:0][31:0] or_rout;

  task automatic clear_logs(input logic [ADDR_W-1:0] base, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(base + ADDR_W'(i));
    cur_base = base; cur_len = len;
    ren_cnt = 0; ren_first = -1; ren_last = -1;
    iv_cnt = 0; iv_first = -1; iv_last = -1;
    or_cnt = 0; or_cyc = -1; all1_first = -1;
    rv_cnt = 0; rv_first = -1; hs_cyc = -1;
    done_cnt = 0; done_cyc = -1;
    or_rout = '0;
  endtask

  always @(negedge clk) begin
    logic [ROWS-1:0][7:0] ea, ew;
    int t, k;
    if (rstn) begin
      if (mem_ren) begin
        if (ren_cnt == 0) ren_first = cyc;
        ren_last = cyc;
        ren_cnt++;
        if (exp_q.size() == 0) check("ren_extra", 1, 0);
        else check("raddr", mem_raddr, exp_q.pop_front());
      end
      if (inpvalid) begin
        if (iv_cnt == 0) iv_first = cyc;
        iv_last = cyc;
        iv_cnt++;
        // Pair k lane r reaches the array edge r cycles after its return.
        t = cyc - iv_first;
        for (int r = 0; r < ROWS; r++) begin
          k = t - r;
          if (k >= 0 && k < cur_len) begin
            ea[r] = data_a(cur_base + ADDR_W'(k), r);
            ew[r] = data_w(cur_base + ADDR_W'(k), r);
          end else begin
            ea[r] = '0;
            ew[r] = '0;
          end
        end
        check("ainport", ainport, ea);
        check("winport", winport, ew);
      end
      if ((&rvalidport) && all1_first < 0) all1_first = cyc;
      if (outread) begin
        or_cnt++;
        or_cyc  = cyc;
        or_rout = routport;
      end
      if (res_valid) begin
        if (rv_cnt == 0) rv_first = cyc;
        rv_cnt++;
        check("res_data", res_data, or_rout);
      end
      if (res_valid && res_ready) hs_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_tile(input logic [ADDR_W-1:0] base, input int len, output int acc);
    int n;
    clear_logs(base, len);
    n = 0;
    while (!cmd_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) check("to_cmd_ready", 0, 1);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = LEN_W'(len);
    acc = cyc + 1;             // accepting edge index
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_tile(input logic [ADDR_W-1:0] base, input int len,
                          input int hold, input bit poke);
    int acc, n;
    start_tile(base, len, acc);
    if (len == 0) begin
      repeat (4) @(posedge clk);
      #1;
      check("z_done_cnt", done_cnt, 1);
      check("z_done_cyc", done_cyc, acc);
      check("z_ren_cnt", ren_cnt, 0);
      check("z_iv_cnt", iv_cnt, 0);
      check("z_or_cnt", or_cnt, 0);
      return;
    end
    check("busy_run", busy, 1);
    check("cmd_ready_run", cmd_ready, 0);
    if (poke) begin
      cmd_valid = 1'b1;
      cmd_base  = 16'h1234;
      cmd_len   = 16'd3;
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    n = 0;
    while (!(iv_cnt > 0 && !inpvalid) && n < len + 4 * ROWS + 10) begin
      @(posedge clk); #1; n++;
    end
    if (!(iv_cnt > 0 && !inpvalid)) check("to_inpvalid", 0, 1);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
    rv_all = 1'b1;
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!res_valid) check("to_res_valid", 0, 1);
    repeat (hold) @(posedge clk);
    #1;
    res_ready = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (done_cnt == 0) check("to_done", 0, 1);
    res_ready = 1'b0;
    rv_all    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ren_cnt", ren_cnt, len);
    check("ren_first", ren_first, acc);
    check("ren_contig", ren_last - ren_first, len - 1);
    check("addr_left", exp_q.size(), 0);
    check("iv_cnt", iv_cnt, len + 2 * ROWS - 1);
    check("iv_first", iv_first, acc + 1);
    check("iv_contig", iv_last - iv_first, iv_cnt - 1);
    check("or_cnt", or_cnt, 1);
    check("or_after_all1", (all1_first >= 0) && (or_cyc > all1_first), 1);
    check("res_valid_lat", rv_first, or_cyc + 1);
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_cyc, hs_cyc + 1);
    check("idle_busy", busy, 0);
    check("idle_ready", cmd_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, len;
    cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; res_ready = 1'b0;
    seed_a = $urandom; seed_w = $urandom;
    clear_logs('0, 0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ren", mem_ren, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_inpvalid", inpvalid, 0);
    check("rst_outread", outread, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ain", ainport, 0);
    check("rst_win", winport, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1);

    // basic tile
    run_tile(16'h0000, 4, 0, 1'b0);
    // single pair, lane r = r+1
    dmode = 1;
    run_tile(16'($urandom), 1, 0, 1'b0);
    dmode = 0;
    // zero-length
    run_tile(16'h0040, 0, 0, 1'b0);
    // consumer back-pressure
    run_tile(16'($urandom), $urandom_range(2, 6), 10, 1'b0);
    // address wrap, command offered while busy
    run_tile(16'hFFFE, 4, 0, 1'b1);

    // reset in the middle of STREAM
    start_tile(16'h0100, 20, acc);
    repeat (4) @(posedge clk);
    #1;
    check("mid_ren", mem_ren, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ren", mem_ren, 0);
    check("arst_inpvalid", inpvalid, 0);
    check("arst_outread", outread, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_tile(16'h0200, 3, 2, 1'b0);

    // random tiles
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(0, 12);
      run_tile(16'($urandom), len, $urandom_range(0, 5), (len > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
